// File: rtl/y86_imem_pkg.sv
// Shared types and constants for the Y86 instruction memory and program loader.
// Optional feature macro used by this slice: IMEM_LOAD_CHECKSUM_EN.
package y86_imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } imem_state_t;

    localparam int         FETCH_BYTES = 10;
    localparam int         FETCH_W     = FETCH_BYTES * 8;
    localparam logic [3:0] ICODE_HALT  = 4'h0;

endpackage

// File: rtl/y86_imem_loader_if.sv
// Program-load stream and fetch port of the instruction memory.
// master = program source / CPU side, slave = y86_imem_loader.
interface y86_imem_loader_if
    import y86_imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
);
    logic               load_start;
    logic               load_valid;
    logic [7:0]         load_byte;
    logic               load_last;
    logic               load_ready;
    logic               load_err;
    logic               cpu_run;
    logic [AW:0]        prog_len;

    logic               fetch_req;
    logic [63:0]        fetch_pc;
    logic               fetch_valid;
    logic [FETCH_W-1:0] fetch_bytes;
    logic               fetch_error;

    modport master (
        output load_start, load_valid, load_byte, load_last, fetch_req, fetch_pc,
        input  load_ready, load_err, cpu_run, prog_len, fetch_valid, fetch_bytes, fetch_error
    );

    modport slave (
        input  load_start, load_valid, load_byte, load_last, fetch_req, fetch_pc,
        output load_ready, load_err, cpu_run, prog_len, fetch_valid, fetch_bytes, fetch_error
    );
endinterface

// File: rtl/y86_imem_window.sv
// Combinational 10-byte little-endian read window with loaded-length mask and bounds check.
// Latency: 0 cycles (parent registers the result); no backpressure.
// Backpressure: none, pure function of pc / prog_len / memory contents.
module y86_imem_window
    import y86_imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [7:0]         mem [DEPTH],
    input  logic [63:0]        pc,
    input  logic [AW:0]        prog_len,
    output logic [FETCH_W-1:0] bytes,
    output logic               err
);
    logic [64:0] end_addr;

    // 65-bit sum so a pc near 2^64 cannot wrap back into range
    assign end_addr = {1'b0, pc} + 65'(FETCH_BYTES - 1);
    assign err      = (end_addr >= 65'(DEPTH));

    for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_byte
        localparam logic [AW:0] OFS = i;
        logic [AW:0] addr;

        assign addr = {1'b0, pc[AW-1:0]} + OFS;
        assign bytes[i*8 +: 8] = err                 ? 8'h00 :
                                 (addr < prog_len)   ? mem[addr[AW-1:0]] :
                                                       {ICODE_HALT, 4'h0};
    end
endmodule

// File: rtl/y86_imem_loader.sv
// Y86 instruction memory: streamed byte-wide program load FSM, then 10-byte fetch window for SEQ.
// Latency: fetch result 1 cycle after fetch_req; load byte stored the cycle it is accepted.
// Backpressure: load_ready high only in LOAD; fetch has none. IMEM_LOAD_CHECKSUM_EN adds a trailing checksum beat.
module y86_imem_loader
    import y86_imem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    y86_imem_loader_if.slave bus
);
    localparam logic [AW:0] PTR_FULL = DEPTH;
    localparam logic [AW:0] PTR_ONE  = 1;

    imem_state_t        state, state_nxt;
    logic [AW:0]        wr_ptr;
    logic [7:0]         mem [DEPTH];
    logic               beat;
    logic               mem_we;
    logic               ptr_inc;
    logic               fetch_fire;
    logic [FETCH_W-1:0] win_bytes;
    logic               win_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]         sum;
`endif

    // a load_start in the same cycle as a beat discards the beat
    assign beat       = bus.load_valid && (state == LOAD) && !bus.load_start;
    assign fetch_fire = bus.fetch_req && (state == RUN);

    assign bus.load_ready = (state == LOAD);
    assign bus.load_err   = (state == ERR);
    assign bus.cpu_run    = (state == RUN);
    assign bus.prog_len   = wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        ptr_inc   = 1'b0;
        case (state)
            LOAD: begin
                if (beat) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    if (bus.load_last) begin
                        state_nxt = (sum == bus.load_byte) ? RUN : ERR;
                    end else if (wr_ptr == PTR_FULL) begin
                        state_nxt = ERR;
                    end else begin
                        mem_we  = 1'b1;
                        ptr_inc = 1'b1;
                    end
`else
                    if (wr_ptr == PTR_FULL) begin
                        state_nxt = ERR;
                    end else begin
                        mem_we  = 1'b1;
                        ptr_inc = 1'b1;
                        if (bus.load_last) state_nxt = RUN;
                    end
`endif
                end
            end
            default: ;
        endcase
        if (bus.load_start) state_nxt = LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (bus.load_start) begin
            wr_ptr <= '0;
        end else if (ptr_inc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (bus.load_start) begin
            sum <= '0;
        end else if (ptr_inc) begin
            sum <= sum + bus.load_byte;
        end
    end
`endif

    // storage is deliberately left unreset; the length mask hides stale bytes
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= bus.load_byte;
    end

    y86_imem_window #(
        .DEPTH (DEPTH)
    ) u_window (
        .mem      (mem),
        .pc       (bus.fetch_pc),
        .prog_len (wr_ptr),
        .bytes    (win_bytes),
        .err      (win_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fetch_valid <= 1'b0;
            bus.fetch_bytes <= '0;
            bus.fetch_error <= 1'b0;
        end else begin
            bus.fetch_valid <= fetch_fire;
            if (fetch_fire) begin
                bus.fetch_bytes <= win_bytes;
                bus.fetch_error <= win_err;
            end
        end
    end
endmodule

// File: tb/tb_y86_imem_loader.sv
// Randomized scoreboard bench for y86_imem_loader; honours IMEM_LOAD_CHECKSUM_EN when defined.
module tb_y86_imem_loader;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic        err;
        logic [79:0] bytes;
    } fexp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    y86_imem_loader_if #(.DEPTH(DEPTH)) bus ();

    y86_imem_loader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  m_prog[$];
    bit          m_run;
    fexp_t       sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [79:0] last_bytes;
    logic        last_err;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: the window is simply the loaded program bytes, zero past the end, error if it leaves memory.
    function automatic fexp_t model_fetch(input logic [63:0] pc);
        fexp_t       r;
        logic [64:0] end_a;
        int          idx;
        end_a   = {1'b0, pc} + 65'd9;
        r.bytes = '0;
        r.err   = (end_a >= 65'(DEPTH));
        if (!r.err) begin
            for (int i = 0; i < 10; i++) begin
                idx = int'(pc[31:0]) + i;
                if (idx < m_prog.size()) r.bytes[i*8 +: 8] = m_prog[idx];
            end
        end
        return r;
    endfunction

    initial begin : monitor
        fexp_t e;
        forever begin
            @(negedge clk);
            if (bus.fetch_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_fetch_valid: got valid=1 pc=%h, expected no result", bus.fetch_pc);
                end else begin
                    e = sb.pop_front();
                    last_bytes = bus.fetch_bytes;
                    last_err   = bus.fetch_error;
                    chk("fetch_bytes", bus.fetch_bytes, e.bytes);
                    chk("fetch_error", 80'(bus.fetch_error), 80'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        m_prog.delete();
        m_run = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        while (bus.load_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL load_ready_timeout: got load_ready=%b after %0d cycles, expected 1", bus.load_ready, guard);
        end
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] q[$], input bit gaps);
        logic [7:0] cs;
        cs = 8'h00;
        start_load();
        for (int i = 0; i < q.size(); i++) begin
            cs = cs + q[i];
`ifdef IMEM_LOAD_CHECKSUM_EN
            send_beat(q[i], 1'b0);
`else
            send_beat(q[i], i == q.size() - 1);
`endif
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_beat(cs, 1'b1);
`endif
        m_prog = q;
        m_run  = 1'b1;
    endtask

    task automatic fetch(input logic [63:0] pc);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        if (m_run) sb.push_back(model_fetch(pc));
        tick();
    endtask

    task automatic expect_no_fetch(input string name, input logic [63:0] pc);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        tick();
        bus.fetch_req = 1'b0;
        @(negedge clk);
        chk(name, 80'(bus.fetch_valid), 80'd0);
        tick();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.fetch_req = 1'b0;
        while (sb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
    endtask

    initial begin : stim
        logic [7:0] q[$];
        int         len;

        bus.load_start = 0; bus.load_valid = 0; bus.load_byte = 0; bus.load_last = 0;
        bus.fetch_req  = 0; bus.fetch_pc   = 0;
        m_run = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_ready",  80'(bus.load_ready),  80'd0);
        chk("rst_load_err",    80'(bus.load_err),    80'd0);
        chk("rst_cpu_run",     80'(bus.cpu_run),     80'd0);
        chk("rst_prog_len",    80'(bus.prog_len),    80'd0);
        chk("rst_fetch_valid", 80'(bus.fetch_valid), 80'd0);
        chk("rst_fetch_bytes", bus.fetch_bytes,      80'd0);
        chk("rst_fetch_error", 80'(bus.fetch_error), 80'd0);
        rst_n = 1'b1;
        tick();

        expect_no_fetch("idle_no_fetch", 64'd0);

        // example program: irmovq fragment
        q = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00};
        load_prog(q, 1'b0);
        chk("ex_cpu_run",    80'(bus.cpu_run),    80'd1);
        chk("ex_prog_len",   80'(bus.prog_len),   80'd6);
        chk("ex_load_ready", 80'(bus.load_ready), 80'd0);
        fetch(64'd0);
        drain();
        chk("ex_window", last_bytes, 80'h0000_0000_0000_000A_F230);
        chk("ex_error",  80'(last_err), 80'd0);

        // back-to-back fetches over the short program
        for (int i = 0; i < 20; i++) fetch(64'($urandom_range(0, 12)));
        drain();

        // random program with random valid gaps
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 40);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            load_prog(q, 1'b1);
            chk("rnd_prog_len", 80'(bus.prog_len), 80'(len));
            for (int i = 0; i < 15; i++) fetch(64'($urandom_range(0, len + 5)));
            fetch(64'(DEPTH - 10));
            fetch(64'(DEPTH - 9));
            fetch(64'hFFFF_FFFF_FFFF_FFFC);
            fetch(64'h0000_0001_0000_0000);
            drain();
        end

        // full memory, window edges
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
        load_prog(q, 1'b0);
        chk("full_prog_len", 80'(bus.prog_len), 80'(DEPTH));
        fetch(64'(DEPTH - 10));
        fetch(64'(DEPTH - 9));
        fetch(64'(DEPTH - 11));
        fetch(64'd0);
        fetch(64'($urandom_range(0, DEPTH - 1)));
        drain();

        // overflow: DEPTH+1 beats without last
        start_load();
        for (int i = 0; i <= DEPTH; i++) send_beat(8'($urandom), 1'b0);
        chk("ovf_load_err",    80'(bus.load_err),   80'd1);
        chk("ovf_cpu_run",     80'(bus.cpu_run),    80'd0);
        chk("ovf_load_ready",  80'(bus.load_ready), 80'd0);
        expect_no_fetch("err_no_fetch", 64'd0);
        chk("ovf_err_sticky",  80'(bus.load_err),   80'd1);
        start_load();
        chk("ovf_restart_ready", 80'(bus.load_ready), 80'd1);
        chk("ovf_restart_err",   80'(bus.load_err),   80'd0);
        chk("ovf_restart_len",   80'(bus.prog_len),   80'd0);

        // load_start and a beat together: beat dropped
        bus.load_valid = 1'b1; bus.load_byte = 8'h55; bus.load_start = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.load_start = 1'b0;
        chk("start_beat_len", 80'(bus.prog_len), 80'd0);

        // reset in the middle of a load
        for (int i = 0; i < 3; i++) send_beat(8'(i + 1), 1'b0);
        chk("midload_len", 80'(bus.prog_len), 80'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_prog_len",   80'(bus.prog_len),   80'd0);
        chk("midrst_load_ready", 80'(bus.load_ready), 80'd0);
        tick();
        rst_n = 1'b1;
        m_prog.delete();
        m_run = 1'b0;
        tick();
        chk("midrst_cpu_run", 80'(bus.cpu_run), 80'd0);
        expect_no_fetch("midrst_no_fetch", 64'd0);

        // reload while running
        q = '{8'h11, 8'h22, 8'h33};
        load_prog(q, 1'b0);
        chk("reload_run1", 80'(bus.cpu_run), 80'd1);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("reload_cpu_run", 80'(bus.cpu_run),    80'd0);
        chk("reload_ready",   80'(bus.load_ready), 80'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_beat(8'h00, 1'b0);
        send_beat(8'h00, 1'b1);
`else
        send_beat(8'h00, 1'b1);
`endif
        m_prog = '{8'h00};
        m_run  = 1'b1;
        fetch(64'd0);
        drain();
        chk("reload_zero_window", last_bytes, 80'd0);

`ifdef IMEM_LOAD_CHECKSUM_EN
        start_load();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b1);
        chk("cs_good_run", 80'(bus.cpu_run),  80'd1);
        chk("cs_good_len", 80'(bus.prog_len), 80'd2);
        start_load();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h04, 1'b1);
        chk("cs_bad_err", 80'(bus.load_err), 80'd1);
        chk("cs_bad_run", 80'(bus.cpu_run),  80'd0);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
